// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero register, write bypass and busy scoreboard.
// Latency: one cycle from rd_i to out_o/busy_out_o; writes and busy updates take effect at the next edge.
// Backpressure: none; read results hold while rd_i is low, and every request is accepted on each edge.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic [AW-1:0]       selwr_i,
    input  logic [XLEN-1:0]     in_i,
    input  logic                rd_i,
    input  logic [NRD*AW-1:0]   selrd_i,
    output logic [NRD*XLEN-1:0] out_o,
    input  logic                busy_set_i,
    input  logic [AW-1:0]       busy_sel_i,
    output logic [NRD-1:0]      busy_out_o
);

    localparam int NREG = 2 ** AW;

    // Architectural state: flat flop array plus one pending-write bit per register.
    logic [XLEN-1:0]     rfile_q [NREG];
    logic [NREG-1:0]     busy_q;
    logic [NREG-1:0]     busy_d;

    // Registered read results.
    logic [NRD*XLEN-1:0] out_q;
    logic [NRD*XLEN-1:0] out_d;
    logic [NRD-1:0]      busy_out_q;
    logic [NRD-1:0]      busy_out_d;

    // Qualified requests: register 0 swallows writes and busy marks when hardwired.
    logic                wr_eff;
    logic                set_eff;

    // Suppress writes / busy marks aimed at the hardwired zero register.
    always_comb begin
        wr_eff  = wr_i;
        set_eff = busy_set_i;
        if (ZERO_REG != 0) begin
            if (selwr_i == '0) begin
                wr_eff = 1'b0;
            end
            if (busy_sel_i == '0) begin
                set_eff = 1'b0;
            end
        end
    end

    // Scoreboard next state: a write retires its producer, a new issue re-marks it;
    // issue is applied last so it wins when both hit the same register on one edge.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[selwr_i] = 1'b0;
        end
        if (set_eff) begin
            busy_d[busy_sel_i] = 1'b1;
        end
    end

    // Read-port selection: zero register, optional forwarding of this edge's write, else stored value.
    always_comb begin
        logic [AW-1:0] rsel;
        rsel       = '0;
        out_d      = out_q;
        busy_out_d = busy_out_q;
        if (rd_i) begin
            for (int k = 0; k < NRD; k++) begin
                rsel = selrd_i[k*AW +: AW];
                if ((ZERO_REG != 0) && (rsel == '0)) begin
                    out_d[k*XLEN +: XLEN] = '0;
                    busy_out_d[k]         = 1'b0;
                end else begin
                    if ((BYPASS != 0) && wr_eff && (selwr_i == rsel)) begin
                        out_d[k*XLEN +: XLEN] = in_i;
                    end else begin
                        out_d[k*XLEN +: XLEN] = rfile_q[rsel];
                    end
                    // Bypass reports the scoreboard as it will be after this edge.
                    if (BYPASS != 0) begin
                        busy_out_d[k] = busy_d[rsel];
                    end else begin
                        busy_out_d[k] = busy_q[rsel];
                    end
                end
            end
        end
    end

    // Register array: reset loads each register with its own index (reg 0 = 0).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                rfile_q[i] <= XLEN'(i);
            end
        end else if (wr_eff) begin
            rfile_q[selwr_i] <= in_i;
        end
    end

    // Scoreboard and read-result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            out_q      <= '0;
            busy_out_q <= '0;
        end else begin
            busy_q     <= busy_d;
            out_q      <= out_d;
            busy_out_q <= busy_out_d;
        end
    end

    assign out_o      = out_q;
    assign busy_out_o = busy_out_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances share stimulus, one with bypass and one without.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants per step.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr;
    logic [AW-1:0]       selwr;
    logic [XLEN-1:0]     din;
    logic                rd;
    logic [NRD*AW-1:0]   selrd;
    logic                busy_set;
    logic [AW-1:0]       busy_sel;
    logic [NRD*XLEN-1:0] out_bp;
    logic [NRD-1:0]      busy_bp;
    logic [NRD*XLEN-1:0] out_nb;
    logic [NRD-1:0]      busy_nb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk_i(clk), .rst_i(rst), .wr_i(wr), .selwr_i(selwr), .in_i(din),
        .rd_i(rd), .selrd_i(selrd), .out_o(out_bp),
        .busy_set_i(busy_set), .busy_sel_i(busy_sel), .busy_out_o(busy_bp)
    );

    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .wr_i(wr), .selwr_i(selwr), .in_i(din),
        .rd_i(rd), .selrd_i(selrd), .out_o(out_nb),
        .busy_set_i(busy_set), .busy_sel_i(busy_sel), .busy_out_o(busy_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; busy_set = 1'b0;
    endtask

    function automatic logic [NRD*AW-1:0] sel2(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        return {p1, p0};
    endfunction

    // Compare both ports of both instances against expected data and busy flags.
    task automatic check_all(input string tag,
                             input logic [31:0] bp0, input logic [31:0] bp1, input logic [1:0] bbp,
                             input logic [31:0] nb0, input logic [31:0] nb1, input logic [1:0] bnb);
        check({tag, " bp.out0"}, 64'(out_bp[31:0]),  64'(bp0));
        check({tag, " bp.out1"}, 64'(out_bp[63:32]), 64'(bp1));
        check({tag, " bp.busy"}, 64'(busy_bp),       64'(bbp));
        check({tag, " nb.out0"}, 64'(out_nb[31:0]),  64'(nb0));
        check({tag, " nb.out1"}, 64'(out_nb[63:32]), 64'(nb1));
        check({tag, " nb.busy"}, 64'(busy_nb),       64'(bnb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; selwr = '0; din = '0; selrd = '0; busy_sel = '0;
        idle();
        #3;
        check_all("reset", 0, 0, 2'b00, 0, 0, 2'b00);

        // Reads requested while reset is held must not load anything.
        rd = 1'b1; selrd = sel2(5'd1, 5'd31);
        wr = 1'b1; selwr = 5'd1; din = 32'hCAFE_F00D;
        busy_set = 1'b1; busy_sel = 5'd1;
        step(); step();
        check_all("in_reset", 0, 0, 2'b00, 0, 0, 2'b00);
        idle();
        rst = 1'b0;

        // 1. Reset contents: reg i holds i.
        rd = 1'b1; selrd = sel2(5'd1, 5'd31);
        step();
        check_all("rst_vals", 1, 31, 2'b00, 1, 31, 2'b00);

        // 2. Write then read; rd=0 keeps previous outputs.
        idle(); wr = 1'b1; selwr = 5'd5; din = 32'hDEAD_BEEF;
        step();
        check_all("hold", 1, 31, 2'b00, 1, 31, 2'b00);
        idle(); rd = 1'b1; selrd = sel2(5'd5, 5'd6);
        step();
        check_all("wr_rd", 32'hDEAD_BEEF, 6, 2'b00, 32'hDEAD_BEEF, 6, 2'b00);

        // 3. Same-edge write and read of reg 7.
        idle(); wr = 1'b1; selwr = 5'd7; din = 32'h1234;
        rd = 1'b1; selrd = sel2(5'd2, 5'd7);
        step();
        check_all("bypass", 2, 32'h1234, 2'b00, 2, 7, 2'b00);
        idle(); rd = 1'b1; selrd = sel2(5'd7, 5'd7);
        step();
        check_all("after_byp", 32'h1234, 32'h1234, 2'b00, 32'h1234, 32'h1234, 2'b00);

        // 4. Zero register: write and busy mark to reg 0 are ignored, no forwarding either.
        idle(); wr = 1'b1; selwr = 5'd0; din = 32'hFFFF_FFFF;
        busy_set = 1'b1; busy_sel = 5'd0;
        rd = 1'b1; selrd = sel2(5'd0, 5'd0);
        step();
        check_all("zero_same", 0, 0, 2'b00, 0, 0, 2'b00);
        idle(); rd = 1'b1; selrd = sel2(5'd0, 5'd0);
        step();
        check_all("zero_next", 0, 0, 2'b00, 0, 0, 2'b00);

        // 5. Scoreboard.
        idle(); busy_set = 1'b1; busy_sel = 5'd3;
        rd = 1'b1; selrd = sel2(5'd3, 5'd4);
        step();
        check_all("bset_same", 3, 4, 2'b01, 3, 4, 2'b00);
        idle(); rd = 1'b1; selrd = sel2(5'd3, 5'd3);
        step();
        check_all("bset_next", 3, 3, 2'b11, 3, 3, 2'b11);
        idle(); wr = 1'b1; selwr = 5'd3; din = 32'hAAAA;
        rd = 1'b1; selrd = sel2(5'd3, 5'd1);
        step();
        check_all("wr_clear", 32'hAAAA, 1, 2'b00, 3, 1, 2'b01);
        idle(); rd = 1'b1; selrd = sel2(5'd3, 5'd1);
        step();
        check_all("cleared", 32'hAAAA, 1, 2'b00, 32'hAAAA, 1, 2'b00);
        idle(); wr = 1'b1; selwr = 5'd3; din = 32'h5555;
        busy_set = 1'b1; busy_sel = 5'd3;
        rd = 1'b1; selrd = sel2(5'd3, 5'd5);
        step();
        check_all("set_wins", 32'h5555, 32'hDEAD_BEEF, 2'b01, 32'hAAAA, 32'hDEAD_BEEF, 2'b00);
        idle(); rd = 1'b1; selrd = sel2(5'd3, 5'd3);
        step();
        check_all("set_wins2", 32'h5555, 32'h5555, 2'b11, 32'h5555, 32'h5555, 2'b11);

        // 6. Async reset mid-operation.
        idle(); wr = 1'b1; selwr = 5'd9; din = 32'h9999_0000;
        step();
        idle(); busy_set = 1'b1; busy_sel = 5'd9;
        step();
        idle(); rd = 1'b1; selrd = sel2(5'd9, 5'd3);
        step();
        check_all("pre_arst", 32'h9999_0000, 32'h5555, 2'b11, 32'h9999_0000, 32'h5555, 2'b11);
        idle();
        #2 rst = 1'b1;
        #1;
        check_all("arst", 0, 0, 2'b00, 0, 0, 2'b00);
        step();
        rst = 1'b0;
        rd = 1'b1; selrd = sel2(5'd9, 5'd3);
        step();
        check_all("post_arst", 9, 3, 2'b00, 9, 3, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
